// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB3-Lite HTRANS/HBURST/HRESP encodings and the burst-length helper
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  function automatic logic [3:0] burst_len(input logic [2:0] hburst);
    return (hburst == HBURST_WRAP4  || hburst == HBURST_INCR4)  ? 4'd2  :
           (hburst == HBURST_WRAP8  || hburst == HBURST_INCR8)  ? 4'd6  :
           (hburst == HBURST_WRAP16 || hburst == HBURST_INCR16) ? 4'd14 : 4'd0;
  endfunction
endpackage

// File: rtl/ahb3lite_mlayer_addr_decode.sv
// ahb3lite_mlayer_addr_decode: addr + mask/base windows -> lowest-index one-hot sel, no_hit flag, binary idx
module ahb3lite_mlayer_addr_decode #(
  parameter int HADDR_SIZE = 32,
  parameter int SLAVES     = 8,
  localparam int SW        = SLAVES > 1 ? $clog2(SLAVES) : 1
) (
  input  logic [HADDR_SIZE-1:0] addr,
  input  logic [HADDR_SIZE-1:0] mask [SLAVES],
  input  logic [HADDR_SIZE-1:0] base [SLAVES],
  output logic [SLAVES-1:0]     sel,
  output logic                  no_hit,
  output logic [SW-1:0]         idx
);
  always_comb begin
    sel    = '0;
    no_hit = 1'b1;
    idx    = '0;
    for (int i = SLAVES - 1; i >= 0; i--)
      if ((addr & mask[i]) == (base[i] & mask[i])) begin
        sel    = SLAVES'(1) << i;
        no_hit = 1'b0;
        idx    = SW'(i);
      end
  end
endmodule

// File: rtl/ahb3lite_mlayer_master_port.sv
// ahb3lite_mlayer_master_port: AHB slave facing one master (mst_*), decodes and requests slave ports (slv*), default ERROR slave, can_switch/grant handshake
module ahb3lite_mlayer_master_port
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE    = 32,
  parameter int HDATA_SIZE    = 32,
  parameter int SLAVES        = 8,
  parameter int PRIORITY_BITS = 3
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [PRIORITY_BITS-1:0] mst_priority,
  input  logic                     mst_HSEL,
  input  logic [HADDR_SIZE-1:0]    mst_HADDR,
  input  logic [HDATA_SIZE-1:0]    mst_HWDATA,
  input  logic                     mst_HWRITE,
  input  logic [2:0]               mst_HSIZE,
  input  logic [2:0]               mst_HBURST,
  input  logic [3:0]               mst_HPROT,
  input  logic [1:0]               mst_HTRANS,
  input  logic                     mst_HMASTLOCK,
  input  logic                     mst_HREADY,
  output logic [HDATA_SIZE-1:0]    mst_HRDATA,
  output logic                     mst_HREADYOUT,
  output logic                     mst_HRESP,
  input  logic [HADDR_SIZE-1:0]    slvHADDRmask [SLAVES],
  input  logic [HADDR_SIZE-1:0]    slvHADDRbase [SLAVES],
  output logic [SLAVES-1:0]        slvHSEL,
  output logic [HADDR_SIZE-1:0]    slvHADDR,
  output logic [HDATA_SIZE-1:0]    slvHWDATA,
  output logic                     slvHWRITE,
  output logic [2:0]               slvHSIZE,
  output logic [2:0]               slvHBURST,
  output logic [3:0]               slvHPROT,
  output logic [1:0]               slvHTRANS,
  output logic                     slvHMASTLOCK,
  input  logic [HDATA_SIZE-1:0]    slvHRDATA [SLAVES],
  input  logic [SLAVES-1:0]        slvHREADY,
  input  logic [SLAVES-1:0]        slvHRESP,
  output logic                     slvHREADYOUT,
  output logic [PRIORITY_BITS-1:0] slvpriority,
  output logic                     can_switch,
  input  logic [SLAVES-1:0]        master_granted
);
  localparam int SW = SLAVES > 1 ? $clog2(SLAVES) : 1;
  typedef enum logic [2:0] {NO_ACCESS, PENDING, GRANTED, ERR1, ERR2} state_t;
  state_t state, nxt, na_next;
  logic [SLAVES-1:0] live_sel, reg_sel;
  logic live_miss, reg_miss;
  logic [SW-1:0] live_idx, reg_idx, slave_sel;
  logic reg_hsel, reg_hwrite, reg_hmastlock, local_ready;
  logic [HADDR_SIZE-1:0] reg_haddr;
  logic [2:0] reg_hsize, reg_hburst;
  logic [3:0] reg_hprot, burst_cnt;
  logic [1:0] reg_htrans;
  logic [PRIORITY_BITS-1:0] reg_priority;
  logic active, hit, dec_err, live_gnt, pend, reg_req, boundary, granted_cs;
  ahb3lite_mlayer_addr_decode #(.HADDR_SIZE(HADDR_SIZE), .SLAVES(SLAVES)) u_live_dec (
    .addr(mst_HADDR), .mask(slvHADDRmask), .base(slvHADDRbase),
    .sel(live_sel), .no_hit(live_miss), .idx(live_idx)
  );
  ahb3lite_mlayer_addr_decode #(.HADDR_SIZE(HADDR_SIZE), .SLAVES(SLAVES)) u_reg_dec (
    .addr(reg_haddr), .mask(slvHADDRmask), .base(slvHADDRbase),
    .sel(reg_sel), .no_hit(reg_miss), .idx(reg_idx)
  );
  assign active   = mst_HSEL & mst_HTRANS[1];
  assign hit      = active & ~live_miss;
  assign dec_err  = active & live_miss;
  assign live_gnt = master_granted[live_idx];
  assign pend     = state == PENDING;
  assign reg_req  = reg_hsel & reg_htrans[1] & ~reg_miss;
  assign na_next  = !mst_HREADY ? NO_ACCESS :
                    dec_err     ? ERR1      :
                    hit         ? (live_gnt ? GRANTED : PENDING) : NO_ACCESS;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= NO_ACCESS;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      NO_ACCESS, ERR2: nxt = na_next;
      PENDING:         nxt = (master_granted[reg_idx] & slvHREADY[reg_idx]) ? GRANTED : PENDING;
      GRANTED:         nxt = mst_HREADY ? na_next : GRANTED;
      ERR1:            nxt = ERR2;
      default:         nxt = NO_ACCESS;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      reg_hsel      <= 1'b0;
      reg_haddr     <= '0;
      reg_hwrite    <= 1'b0;
      reg_hsize     <= '0;
      reg_hburst    <= HBURST_SINGLE;
      reg_hprot     <= '0;
      reg_htrans    <= HTRANS_IDLE;
      reg_hmastlock <= 1'b0;
      reg_priority  <= '0;
      slave_sel     <= '0;
      local_ready   <= 1'b1;
      burst_cnt     <= '0;
    end else if (mst_HREADY) begin
      reg_hsel      <= mst_HSEL;
      reg_haddr     <= mst_HADDR;
      reg_hwrite    <= mst_HWRITE;
      reg_hsize     <= mst_HSIZE;
      reg_hburst    <= mst_HBURST;
      reg_hprot     <= mst_HPROT;
      reg_htrans    <= mst_HTRANS;
      reg_hmastlock <= mst_HMASTLOCK;
      reg_priority  <= mst_priority;
      slave_sel     <= live_idx;
      local_ready   <= ~active;
      burst_cnt     <= mst_HTRANS == HTRANS_NONSEQ ? burst_len(mst_HBURST) :
                       mst_HTRANS == HTRANS_SEQ    ? burst_cnt - 4'd1 : burst_cnt;
    end
  // a slave port sees an undefined-length burst resume as a fresh NONSEQ after a stall
  assign slvHSEL      = pend ? ({SLAVES{reg_req}} & reg_sel) : ({SLAVES{hit}} & live_sel);
  assign slvHADDR     = pend ? reg_haddr     : mst_HADDR;
  assign slvHWRITE    = pend ? reg_hwrite    : mst_HWRITE;
  assign slvHSIZE     = pend ? reg_hsize     : mst_HSIZE;
  assign slvHBURST    = pend ? reg_hburst    : mst_HBURST;
  assign slvHPROT     = pend ? reg_hprot     : mst_HPROT;
  assign slvHMASTLOCK = pend ? reg_hmastlock : mst_HMASTLOCK;
  assign slvpriority  = pend ? reg_priority  : mst_priority;
  assign slvHTRANS    = !pend ? mst_HTRANS :
                        (reg_htrans == HTRANS_SEQ && reg_hburst == HBURST_INCR) ? HTRANS_NONSEQ : reg_htrans;
  assign slvHWDATA    = mst_HWDATA;
  assign slvHREADYOUT = pend ? slvHREADY[reg_idx] : mst_HREADY & |(live_sel & slvHREADY);
  assign mst_HRDATA    = slvHRDATA[slave_sel];
  assign mst_HREADYOUT = state == GRANTED ? slvHREADY[slave_sel] :
                         state == ERR1    ? 1'b0 :
                         state == ERR2    ? 1'b1 : local_ready;
  assign mst_HRESP     = state == GRANTED ? slvHRESP[slave_sel] :
                         (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign boundary   = mst_HTRANS == HTRANS_IDLE ||
                      (mst_HTRANS == HTRANS_NONSEQ && mst_HBURST == HBURST_SINGLE) ||
                      (mst_HTRANS == HTRANS_SEQ && mst_HBURST > HBURST_INCR && burst_cnt == 4'd0);
  assign granted_cs = ~mst_HSEL | (~mst_HMASTLOCK & mst_HREADY & boundary);
  assign can_switch = state == NO_ACCESS ? ~(hit & live_gnt) :
                      state == PENDING   ? ~master_granted[reg_idx] :
                      state == GRANTED   ? granted_cs : 1'b1;
endmodule

// File: tb/tb_ahb3lite_mlayer_master_port.sv
// tb_ahb3lite_mlayer_master_port: directed vector table plus pending, conversion and reset sequences
module tb_ahb3lite_mlayer_master_port;
  localparam int S = 8;
  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SG = 3'd0, IN = 3'd1, I4 = 3'd3;
  typedef struct {
    logic sel; logic [1:0] tr; logic [31:0] ad; logic [2:0] bu; logic wr; logic lk; logic [7:0] gn;
    logic [7:0] e_hsel; logic e_rdy; logic e_resp; logic e_cs; logic [31:0] e_ad; logic [1:0] e_tr;
  } vec_t;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [2:0] mst_priority;
  logic mst_HSEL, mst_HWRITE, mst_HMASTLOCK, mst_HREADY;
  logic [31:0] mst_HADDR, mst_HWDATA, mst_HRDATA;
  logic [2:0] mst_HSIZE, mst_HBURST;
  logic [3:0] mst_HPROT;
  logic [1:0] mst_HTRANS;
  logic mst_HREADYOUT, mst_HRESP;
  logic [31:0] mask [S], base [S], slvHRDATA [S];
  logic [S-1:0] slvHSEL, slvHREADY, slvHRESP, master_granted;
  logic [31:0] slvHADDR, slvHWDATA;
  logic slvHWRITE, slvHMASTLOCK, slvHREADYOUT, can_switch;
  logic [2:0] slvHSIZE, slvHBURST, slvpriority;
  logic [3:0] slvHPROT;
  logic [1:0] slvHTRANS;
  int n_cmp = 0, n_err = 0;
  always #5 HCLK = ~HCLK;
  assign mst_HREADY = mst_HREADYOUT;
  ahb3lite_mlayer_master_port #(.HADDR_SIZE(32), .HDATA_SIZE(32), .SLAVES(S), .PRIORITY_BITS(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mst_priority(mst_priority),
    .mst_HSEL(mst_HSEL), .mst_HADDR(mst_HADDR), .mst_HWDATA(mst_HWDATA), .mst_HWRITE(mst_HWRITE),
    .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST), .mst_HPROT(mst_HPROT), .mst_HTRANS(mst_HTRANS),
    .mst_HMASTLOCK(mst_HMASTLOCK), .mst_HREADY(mst_HREADY), .mst_HRDATA(mst_HRDATA),
    .mst_HREADYOUT(mst_HREADYOUT), .mst_HRESP(mst_HRESP),
    .slvHADDRmask(mask), .slvHADDRbase(base), .slvHSEL(slvHSEL), .slvHADDR(slvHADDR),
    .slvHWDATA(slvHWDATA), .slvHWRITE(slvHWRITE), .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST),
    .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS), .slvHMASTLOCK(slvHMASTLOCK), .slvHRDATA(slvHRDATA),
    .slvHREADY(slvHREADY), .slvHRESP(slvHRESP), .slvHREADYOUT(slvHREADYOUT),
    .slvpriority(slvpriority), .can_switch(can_switch), .master_granted(master_granted)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] ad, input logic [2:0] bu,
                       input logic wr, input logic lk, input logic [7:0] gn);
    mst_HSEL = sel; mst_HTRANS = tr; mst_HADDR = ad; mst_HBURST = bu;
    mst_HWRITE = wr; mst_HMASTLOCK = lk; master_granted = gn;
  endtask
  initial begin
    vec_t v[$];
    for (int i = 0; i < S; i++) begin
      mask[i] = 32'hF000_0000;
      base[i] = i << 28;
      slvHRDATA[i] = 32'h1111_0000 + i;
    end
    mask[5] = 32'hFFF0_0000; base[5] = 32'h2000_0000;
    slvHRDATA[1] = 32'hCAFE_BABE;
    slvHREADY = '1; slvHRESP = '0;
    mst_priority = 3'd0; mst_HWDATA = 32'hDEAD_BEEF; mst_HSIZE = 3'd2; mst_HPROT = 4'h3;
    drive(0, IDL, 0, SG, 0, 0, 8'h00);
    #12;
    chk("rst slvHSEL", slvHSEL, 0);
    chk("rst slvHTRANS", slvHTRANS, IDL);
    chk("rst HREADYOUT", mst_HREADYOUT, 1);
    chk("rst HRESP", mst_HRESP, 0);
    chk("rst can_switch", can_switch, 1);
    @(negedge HCLK) HRESETn = 1'b1;
    v.push_back('{1, NS,  32'h1000_0000, SG, 0, 0, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0000, NS });
    v.push_back('{1, NS,  32'h1000_0010, SG, 0, 0, 8'h02, 8'h02, 1, 0, 1, 32'h1000_0010, NS });
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h02, 8'h00, 1, 0, 1, 32'h0000_0000, IDL});
    v.push_back('{1, IDL, 32'h1000_0000, SG, 0, 0, 8'h02, 8'h00, 1, 0, 1, 32'h1000_0000, IDL});
    v.push_back('{1, BSY, 32'h1000_0000, IN, 0, 0, 8'h02, 8'h00, 1, 0, 1, 32'h1000_0000, BSY});
    v.push_back('{1, NS,  32'h2000_1000, SG, 0, 0, 8'h04, 8'h04, 1, 0, 0, 32'h2000_1000, NS });
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h00, 8'h00, 1, 0, 1, 32'h0000_0000, IDL});
    v.push_back('{1, NS,  32'hF000_0000, SG, 0, 0, 8'h00, 8'h00, 1, 0, 1, 32'hF000_0000, NS });
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h00, 8'h00, 0, 1, 1, 32'h0000_0000, IDL});
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h00, 8'h00, 1, 1, 1, 32'h0000_0000, IDL});
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h00, 8'h00, 1, 0, 1, 32'h0000_0000, IDL});
    v.push_back('{1, NS,  32'hF000_0000, SG, 0, 0, 8'h00, 8'h00, 1, 0, 1, 32'hF000_0000, NS });
    v.push_back('{1, NS,  32'hF000_0000, SG, 0, 0, 8'h00, 8'h00, 0, 1, 1, 32'hF000_0000, NS });
    v.push_back('{1, NS,  32'h1000_0000, SG, 0, 0, 8'h02, 8'h02, 1, 1, 1, 32'h1000_0000, NS });
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h00, 8'h00, 1, 0, 1, 32'h0000_0000, IDL});
    v.push_back('{1, NS,  32'h1000_0000, I4, 1, 0, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0000, NS });
    v.push_back('{1, SQ,  32'h1000_0004, I4, 1, 0, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0004, SQ });
    v.push_back('{1, SQ,  32'h1000_0008, I4, 1, 0, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0008, SQ });
    v.push_back('{1, SQ,  32'h1000_000C, I4, 1, 0, 8'h02, 8'h02, 1, 0, 1, 32'h1000_000C, SQ });
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h02, 8'h00, 1, 0, 1, 32'h0000_0000, IDL});
    v.push_back('{1, NS,  32'h1000_0000, IN, 0, 0, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0000, NS });
    v.push_back('{1, SQ,  32'h1000_0004, IN, 0, 0, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0004, SQ });
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h02, 8'h00, 1, 0, 1, 32'h0000_0000, IDL});
    v.push_back('{1, NS,  32'h1000_0000, I4, 0, 1, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0000, NS });
    v.push_back('{1, SQ,  32'h1000_0004, I4, 0, 1, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0004, SQ });
    v.push_back('{1, SQ,  32'h1000_0008, I4, 0, 1, 8'h02, 8'h02, 1, 0, 0, 32'h1000_0008, SQ });
    v.push_back('{1, SQ,  32'h1000_000C, I4, 0, 1, 8'h02, 8'h02, 1, 0, 0, 32'h1000_000C, SQ });
    v.push_back('{1, IDL, 32'h1000_0010, I4, 0, 1, 8'h02, 8'h00, 1, 0, 0, 32'h1000_0010, IDL});
    v.push_back('{0, IDL, 32'h0000_0000, SG, 0, 0, 8'h00, 8'h00, 1, 0, 1, 32'h0000_0000, IDL});
    foreach (v[i]) begin
      @(negedge HCLK);
      drive(v[i].sel, v[i].tr, v[i].ad, v[i].bu, v[i].wr, v[i].lk, v[i].gn);
      #2;
      chk($sformatf("v%0d slvHSEL", i), slvHSEL, v[i].e_hsel);
      chk($sformatf("v%0d HREADYOUT", i), mst_HREADYOUT, v[i].e_rdy);
      chk($sformatf("v%0d HRESP", i), mst_HRESP, v[i].e_resp);
      chk($sformatf("v%0d can_switch", i), can_switch, v[i].e_cs);
      chk($sformatf("v%0d slvHADDR", i), slvHADDR, v[i].e_ad);
      chk($sformatf("v%0d slvHTRANS", i), slvHTRANS, v[i].e_tr);
    end
    @(negedge HCLK);
    drive(1, NS, 32'h1000_0000, SG, 0, 0, 8'h00);
    mst_priority = 3'd5;
    #2;
    chk("pend req slvHSEL", slvHSEL, 8'h02);
    chk("pend req can_switch", can_switch, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      drive(0, IDL, 0, SG, 0, 0, 8'h00);
      mst_priority = 3'd2;
      #2;
      chk($sformatf("pend%0d HREADYOUT", k), mst_HREADYOUT, 0);
      chk($sformatf("pend%0d slvHSEL", k), slvHSEL, 8'h02);
      chk($sformatf("pend%0d slvHADDR", k), slvHADDR, 32'h1000_0000);
      chk($sformatf("pend%0d slvpriority", k), slvpriority, 3'd5);
      chk($sformatf("pend%0d can_switch", k), can_switch, 1);
    end
    @(negedge HCLK);
    master_granted = 8'h02;
    #2;
    chk("pend gnt HREADYOUT", mst_HREADYOUT, 0);
    chk("pend gnt slvHREADYOUT", slvHREADYOUT, 1);
    chk("pend gnt can_switch", can_switch, 0);
    @(negedge HCLK);
    #2;
    chk("pend data HREADYOUT", mst_HREADYOUT, 1);
    chk("pend data HRESP", mst_HRESP, 0);
    chk("pend data HRDATA", mst_HRDATA, 32'hCAFE_BABE);
    chk("pend data slvHWDATA", slvHWDATA, 32'hDEAD_BEEF);
    @(negedge HCLK);
    drive(0, IDL, 0, SG, 0, 0, 8'h00);
    #2;
    chk("pend done HREADYOUT", mst_HREADYOUT, 1);
    @(negedge HCLK);
    drive(1, NS, 32'h1000_0000, IN, 0, 0, 8'h02);
    #2;
    chk("incr ns can_switch", can_switch, 0);
    @(negedge HCLK);
    drive(1, SQ, 32'h1000_0004, IN, 0, 0, 8'h00);
    #2;
    chk("incr seq slvHSEL", slvHSEL, 8'h02);
    @(negedge HCLK);
    drive(0, IDL, 0, SG, 0, 0, 8'h00);
    #2;
    chk("incr pend slvHTRANS", slvHTRANS, NS);
    chk("incr pend slvHADDR", slvHADDR, 32'h1000_0004);
    chk("incr pend HREADYOUT", mst_HREADYOUT, 0);
    @(negedge HCLK) master_granted = 8'h02;
    @(negedge HCLK);
    drive(0, IDL, 0, SG, 0, 0, 8'h00);
    #2;
    chk("incr data HREADYOUT", mst_HREADYOUT, 1);
    @(negedge HCLK);
    drive(1, NS, 32'h1000_0000, SG, 0, 0, 8'h00);
    @(negedge HCLK);
    drive(0, IDL, 0, SG, 0, 0, 8'h00);
    #2;
    chk("rstp pend HREADYOUT", mst_HREADYOUT, 0);
    #1 HRESETn = 1'b0;
    #1;
    chk("rstp slvHSEL", slvHSEL, 0);
    chk("rstp HREADYOUT", mst_HREADYOUT, 1);
    chk("rstp can_switch", can_switch, 1);
    chk("rstp slvHTRANS", slvHTRANS, IDL);
    @(negedge HCLK) HRESETn = 1'b1;
    @(negedge HCLK);
    drive(1, NS, 32'hF000_0000, SG, 0, 0, 8'h00);
    @(negedge HCLK);
    drive(0, IDL, 0, SG, 0, 0, 8'h00);
    #2;
    chk("rste err1 HREADYOUT", mst_HREADYOUT, 0);
    chk("rste err1 HRESP", mst_HRESP, 1);
    #1 HRESETn = 1'b0;
    #1;
    chk("rste HRESP", mst_HRESP, 0);
    chk("rste HREADYOUT", mst_HREADYOUT, 1);
    @(negedge HCLK) HRESETn = 1'b1;
    @(negedge HCLK);
    #2;
    chk("rste after HRESP", mst_HRESP, 0);
    chk("rste after HREADYOUT", mst_HREADYOUT, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ahb3lite_mlayer_master_port.md
# ahb3lite_mlayer_master_port

Parametrised master port of the AHB3-Lite multi-layer switch; one instance per AHB master, facing it as an AHB slave. Decodes each address phase against SLAVES address windows and requests the matching slave port. While arbitration is pending, holds the command in a register and stalls the master. Adds three behaviours the previous master port lacks:

- configurable priority width;
- built-in default slave giving the two-cycle AHB ERROR response for unmapped addresses;
- deterministic lowest-index resolution of overlapping windows.

## Interface
Parameters:
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width
- SLAVES, 8, number of slave ports (≥1)
- PRIORITY_BITS, 3, width of mst_priority/slvpriority

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- mst_priority  in  PRIORITY_BITS  master priority
- mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE[3], mst_HBURST[3], mst_HPROT[4], mst_HTRANS[2], mst_HMASTLOCK, mst_HREADY  in  AHB address/data phase from master
- mst_HRDATA  out  HDATA_SIZE  read data
- mst_HREADYOUT  out  1  transfer done
- mst_HRESP  out  1  0=OKAY, 1=ERROR
- slvHADDRmask[SLAVES], slvHADDRbase[SLAVES]  in  HADDR_SIZE each  decode windows
- slvHSEL  out  SLAVES  one-hot request
- slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK  out  forwarded command
- slvHRDATA  in  SLAVES×HDATA_SIZE
- slvHREADY, slvHRESP  in  SLAVES
- slvHREADYOUT  out  1  HREADY toward slave port
- slvpriority  out  PRIORITY_BITS  priority of forwarded command
- can_switch  out  1  slave port may re-arbitrate next cycle
- master_granted  in  SLAVES  grant from each slave port

## Operation
Decode:
- hit[s] = ((HADDR & mask[s]) == (base[s] & mask[s])).
- Request only when HSEL and HTRANS is NONSEQ or SEQ.
- Multiple hits select the lowest index.
- No hit with an active transfer is a decode error.
- IDLE/BUSY transfers never request a slave.

Address-phase register:
- Captures all mst_* command signals and mst_priority when mst_HREADY=1.
- regHTRANS resets to IDLE.

FSM states: NO_ACCESS (reset), PENDING, GRANTED, ERR1, ERR2.
- NO_ACCESS: active decode hit and granted → GRANTED; hit and not granted → PENDING; decode error → ERR1.
- PENDING: the registered request is granted and that slave's HREADY=1 → GRANTED.
- GRANTED, on mst_HREADY:
  - no request → NO_ACCESS;
  - decode error → ERR1;
  - new slave not granted → PENDING.
- ERR1 → ERR2 unconditionally; ERR2 → NO_ACCESS, or follows the NO_ACCESS rules on the new address phase.

Outputs per state:
- PENDING: slvHSEL and command come from registers; slvHTRANS SEQ with INCR is converted to NONSEQ; slvHREADYOUT = slvHREADY[slave_sel].
- Otherwise: slvHSEL = mst_HSEL & decoded one-hot; command passed through; slvHREADYOUT = mst_HREADY & |(hit & slvHREADY).
- GRANTED: mst_HREADYOUT/mst_HRESP/mst_HRDATA come from slave_sel.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- NO_ACCESS/PENDING: local ready with HRESP=0. Local ready is registered: 1 after an idle/unselected phase, 0 after an active phase.

Burst counter:
- Loaded on NONSEQ: WRAP4/INCR4=2, WRAP8/INCR8=6, WRAP16/INCR16=14, else 0.
- Decremented on each SEQ beat accepted with mst_HREADY; 4-bit.

can_switch:
- NO_ACCESS/PENDING: no granted request.
- GRANTED: ~mst_HSEL, or all of:
  - ~HMASTLOCK;
  - mst_HREADY;
  - one of: IDLE, NONSEQ-SINGLE, or SEQ on a fixed-length burst with counter=0.
- ERR1/ERR2: 1.

## Timing
- Reset values:
  - access state NO_ACCESS;
  - slvHSEL=0, slvHTRANS=IDLE;
  - mst_HREADYOUT=1, mst_HRESP=0;
  - can_switch=1;
  - slave_sel=0, local ready=1.
- Granted path: zero added latency; address and data phases pass combinationally.
- Pending path: master stalled ≥1 cycle. The registered command is presented until grant plus slave ready, then GRANTED.
- slave_sel updates only on mst_HREADY.
- Error response: exactly 2 cycles; the master may change HTRANS to IDLE during ERR1, and this must be tolerated.
- Asynchronous reset mid-burst or mid-error: immediate return to reset values; no residual request.
- Locked transfers: can_switch stays 0 across HMASTLOCK sequences, including an IDLE with HMASTLOCK=1.

## Structure
- ahb3lite_pkg (shared, existing) provides HTRANS_*, HBURST_*, HRESP_* and the burst-length function.
- The FSM state enum is local.
- One sub-module: ahb3lite_mlayer_addr_decode, parametrised on HADDR_SIZE/SLAVES. It is combinational and produces the lowest-index one-hot select, a no-hit flag and a binary index. Two instances: live and registered address.

## Test plan
1. Single NONSEQ read at 0x1000_0000; slave 1 window base 0x1000_0000, mask 0xF000_0000; granted → slvHSEL=0x02 same cycle; HRDATA=0xCAFEBABE with HRESP=0, zero wait.
2. Same request with grant withheld 3 cycles → mst_HREADYOUT=0 for 3 cycles; registered HADDR presented; on grant, state GRANTED and the transfer completes.
3. INCR4 write burst, granted → can_switch=0 for beats 1–3 and 1 on beat 4 (counter=0); INCR (undefined length) → can_switch=0 on SEQ.
4. NONSEQ to unmapped 0xF000_0000 → HREADYOUT/HRESP = 0/1, then 1/1; no slvHSEL; back to NO_ACCESS.
5. Overlapping windows on slaves 2 and 5 → slvHSEL=0x04.
6. HRESETn low during PENDING → slvHSEL=0 and HREADYOUT=1 immediately; HMASTLOCK burst → can_switch=0 throughout.
